// File: rtl/prime_pkg.sv
// Shared definitions for the sequential primality tester.
//   state_t        : controller states (IDLE, CHECK, MOD, DONE)
//   FIRST_ODD_DIV  : first trial divisor once 2 has been ruled out
//   prod_width()   : width of the untruncated d*d product for a given operand width
package prime_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MOD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FIRST_ODD_DIV = 3;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/prime_checker_seq_seq_rem.sv
// seq_rem: sequential restoring-division remainder unit.
// Produces dividend % divisor, one quotient bit per clock.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : load operands and begin (must not be issued while active)
//   dividend  : WIDTH-bit unsigned dividend, sampled on start
//   divisor   : WIDTH-bit unsigned divisor, must stay stable until done
//   rem       : WIDTH-bit remainder, valid while done is high
//   done      : one-cycle pulse exactly WIDTH cycles after start
module seq_rem #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic             active_q, active_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] shift_q,  shift_d;   // remaining dividend bits, MSB first
    logic [WIDTH-1:0] rem_q,    rem_d;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    // The partial remainder is always below the divisor, so the result fits WIDTH bits.
    function automatic logic [WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic             b,
                                                  input logic [WIDTH-1:0] dv);
        logic [WIDTH:0] trial;
        trial = {r, b};
        if (trial >= {1'b0, dv}) begin
            trial = trial - {1'b0, dv};
        end
        return trial[WIDTH-1:0];
    endfunction

    // The first step is taken on the start edge itself, so after the
    // remaining WIDTH-1 steps the remainder lands exactly WIDTH cycles later.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        rem_d    = rem_q;
        if (start) begin
            rem_d    = div_step('0, dividend[WIDTH-1], divisor);
            shift_d  = dividend << 1;
            cnt_d    = CW'(WIDTH - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                rem_d   = div_step(rem_q, shift_q[WIDTH-1], divisor);
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            rem_q    <= rem_d;
        end
    end

    assign done = active_q && (cnt_q == '0);
    assign rem  = rem_q;

endmodule

// File: rtl/prime_checker_seq.sv
// prime_checker_seq: multi-cycle primality tester for WIDTH-bit unsigned operands
// using odd trial division up to sqrt(n) and a shared sequential remainder unit.
// Optional build macro PRIME_FACTOR_OUT_EN adds the out_factor port (smallest
// prime factor when composite, 0 otherwise).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/in_ready/in_num     : operand handshake (in_ready high only in IDLE)
//   out_valid/out_ready          : result handshake, result held until accepted
//   out_is_prime                 : 1 when n is prime
//   out_factor (optional)        : smallest prime factor, valid with out_valid
//   busy                         : high whenever not IDLE
module prime_checker_seq
    import prime_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_prime,
`ifdef PRIME_FACTOR_OUT_EN
    output logic [WIDTH-1:0] out_factor,
`endif
    output logic             busy
);

    localparam int PW = prod_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             is_prime_q, is_prime_d;
`ifdef PRIME_FACTOR_OUT_EN
    logic [WIDTH-1:0] factor_q, factor_d;
`endif

    logic             rem_start;
    logic [WIDTH-1:0] rem;
    logic             rem_done;
    logic [PW-1:0]    d_sq;
    logic [PW-1:0]    n_ext;

    // Full-width square: the bound test must not wrap, otherwise large
    // divisors could look smaller than n and the search would overrun.
    assign d_sq  = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
    assign n_ext = {{WIDTH{1'b0}}, n_q};

    seq_rem #(
        .WIDTH(WIDTH)
    ) u_rem (
        .clk      (clk),
        .rst      (rst),
        .start    (rem_start),
        .dividend (n_q),
        .divisor  (d_q),
        .rem      (rem),
        .done     (rem_done)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        d_d        = d_q;
        is_prime_d = is_prime_q;
`ifdef PRIME_FACTOR_OUT_EN
        factor_d   = factor_q;
`endif
        rem_start  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d = in_num;
`ifdef PRIME_FACTOR_OUT_EN
                    factor_d = '0;
`endif
                    if (in_num < WIDTH'(2)) begin
                        is_prime_d = 1'b0;
                        state_d    = DONE;
                    end else if (in_num < WIDTH'(4)) begin
                        is_prime_d = 1'b1;
                        state_d    = DONE;
                    end else if (!in_num[0]) begin
                        is_prime_d = 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
                        factor_d   = WIDTH'(2);
`endif
                        state_d    = DONE;
                    end else begin
                        d_d     = WIDTH'(FIRST_ODD_DIV);
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                if (d_sq > n_ext) begin
                    // No divisor up to sqrt(n) found
                    is_prime_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    rem_start = 1'b1;
                    state_d   = MOD;
                end
            end

            MOD: begin
                // d_q is held here, which keeps the divisor stable for seq_rem
                if (rem_done) begin
                    if (rem == '0) begin
                        is_prime_d = 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
                        factor_d   = d_q;
`endif
                        state_d    = DONE;
                    end else begin
                        d_d     = d_q + WIDTH'(2);
                        state_d = CHECK;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            d_q        <= '0;
            is_prime_q <= 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
            factor_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            d_q        <= d_d;
            is_prime_q <= is_prime_d;
`ifdef PRIME_FACTOR_OUT_EN
            factor_q   <= factor_d;
`endif
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_is_prime = is_prime_q;
`ifdef PRIME_FACTOR_OUT_EN
    assign out_factor   = factor_q;
`endif

endmodule

// File: tb/tb_prime_checker_seq.sv
// Testbench for prime_checker_seq: an 8-bit and a 16-bit instance, a
// scoreboard queue of expected results, one report line per transaction.
// Factor checks are compiled in when PRIME_FACTOR_OUT_EN is defined.
module tb_prime_checker_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, is_prime8, busy8;
    logic [7:0]  in_num8 = '0;
    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0, is_prime16, busy16;
    logic [15:0] in_num16 = '0;
`ifdef PRIME_FACTOR_OUT_EN
    logic [7:0]  factor8;
    logic [15:0] factor16;
`endif

    always #5 clk = ~clk;

    prime_checker_seq #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .in_num       (in_num8),
        .out_valid    (out_valid8),
        .out_ready    (out_ready8),
        .out_is_prime (is_prime8),
`ifdef PRIME_FACTOR_OUT_EN
        .out_factor   (factor8),
`endif
        .busy         (busy8)
    );

    prime_checker_seq #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid16),
        .in_ready     (in_ready16),
        .in_num       (in_num16),
        .out_valid    (out_valid16),
        .out_ready    (out_ready16),
        .out_is_prime (is_prime16),
`ifdef PRIME_FACTOR_OUT_EN
        .out_factor   (factor16),
`endif
        .busy         (busy16)
    );

    typedef struct {
        int unsigned n;
        int unsigned is_prime;
        int unsigned factor;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: plain trial division from 2 for the smallest factor,
    // latency counted as the number of odd divisors the search visits.
    function automatic exp_t model(input int unsigned n, input int unsigned w);
        exp_t e;
        int unsigned f;
        int unsigned k;
        e.n = n;
        f = 0;
        for (int unsigned i = 2; i * i <= n; i++) begin
            if (n % i == 0) begin
                f = i;
                break;
            end
        end
        if (n < 2) begin
            e.is_prime = 0; e.factor = 0; e.lat = 1;
        end else if (f == 0) begin
            e.is_prime = 1; e.factor = 0;
            k = 0;
            for (int unsigned d = 3; d * d <= n; d += 2) k++;
            e.lat = (n < 4) ? 1 : 2 + k * (w + 1);
        end else if (f == 2) begin
            e.is_prime = 0; e.factor = 2; e.lat = 1;
        end else begin
            e.is_prime = 0; e.factor = f;
            k = (f - 3) / 2 + 1;
            e.lat = 1 + k * (w + 1);
        end
        return e;
    endfunction

    function automatic int unsigned r_in_ready(input bit w16);
        return w16 ? 32'(in_ready16) : 32'(in_ready8);
    endfunction
    function automatic int unsigned r_out_valid(input bit w16);
        return w16 ? 32'(out_valid16) : 32'(out_valid8);
    endfunction
    function automatic int unsigned r_busy(input bit w16);
        return w16 ? 32'(busy16) : 32'(busy8);
    endfunction
    function automatic int unsigned r_prime(input bit w16);
        return w16 ? 32'(is_prime16) : 32'(is_prime8);
    endfunction
    function automatic int unsigned r_factor(input bit w16);
`ifdef PRIME_FACTOR_OUT_EN
        return w16 ? 32'(factor16) : 32'(factor8);
`else
        return w16 ? 32'd0 : 32'd0;
`endif
    endfunction

    // Called at a negedge; presents n and returns just after the accept edge's negedge.
    task automatic send(input bit w16, input int unsigned n);
        int cyc;
        cyc = 0;
        while (r_in_ready(w16) == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("in_ready_before n=%0d", n), r_in_ready(w16), 1);
        if (w16) begin in_valid16 = 1'b1; in_num16 = 16'(n); end
        else     begin in_valid8  = 1'b1; in_num8  = 8'(n);  end
        sb.push_back(model(n, w16 ? 16 : 8));
        @(posedge clk);
        @(negedge clk);
        // in_num is ignored outside IDLE; scramble it to prove that
        in_valid16 = 1'b0; in_num16 = 16'($urandom);
        in_valid8  = 1'b0; in_num8  = 8'($urandom);
    endtask

    task automatic run_op(input bit w16, input int unsigned n, input int hold);
        exp_t e;
        int   cyc;
        bit   seen;
        bit   stable;
        int unsigned p0, f0;
        send(w16, n);
        cyc  = 1;
        seen = 0;
        while (cyc < 3000) begin
            if (r_out_valid(w16) != 0) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        if (!seen) begin
            check($sformatf("timeout n=%0d", n), 0, 1);
            return;
        end
        check($sformatf("latency n=%0d", n), cyc, e.lat);
        check($sformatf("is_prime n=%0d", n), r_prime(w16), e.is_prime);
`ifdef PRIME_FACTOR_OUT_EN
        check($sformatf("factor n=%0d", n), r_factor(w16), e.factor);
`endif
        p0 = r_prime(w16);
        f0 = r_factor(w16);
        if (hold > 0) begin
            stable = 1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (r_out_valid(w16) != 1 || r_in_ready(w16) != 0 || r_busy(w16) != 1 ||
                    r_prime(w16) != p0 || r_factor(w16) != f0) stable = 0;
            end
            check($sformatf("hold_stable n=%0d", n), 32'(stable), 1);
        end
        if (w16) out_ready16 = 1'b1; else out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready16 = 1'b0;
        out_ready8  = 1'b0;
        check($sformatf("release_valid n=%0d", n), r_out_valid(w16), 0);
        check($sformatf("release_ready n=%0d", n), r_in_ready(w16), 1);
        check($sformatf("release_busy n=%0d", n), r_busy(w16), 0);
        $display("op w=%0d n=%0d prime=%0d factor=%0d latency=%0d", w16 ? 16 : 8, n, p0, f0, cyc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid8), 0);
        check("reset_busy",      32'(busy8), 0);
        check("reset_in_ready",  32'(in_ready8), 1);
        check("reset_is_prime",  32'(is_prime8), 0);
        check("reset_factor",    r_factor(1'b0), 0);

        for (int i = 0; i <= 4; i++) run_op(1'b0, i, 0);
        run_op(1'b0, 97, 0);
        run_op(1'b0, 221, 0);
        run_op(1'b0, 255, 0);
        run_op(1'b0, 97, 20);

        // Abort during MOD of 221
        send(1'b0, 221);
        repeat (4) @(negedge clk);
        check("midop_busy_before", 32'(busy8), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midop_busy",      32'(busy8), 0);
        check("midop_out_valid", 32'(out_valid8), 0);
        check("midop_in_ready",  32'(in_ready8), 1);
        $display("op w=8 n=221 aborted by reset");

        run_op(1'b0, 9, 0);
        run_op(1'b0, 169, 3);
        for (int i = 0; i < 6; i++) run_op(1'b0, $urandom_range(0, 255), i % 2);

        run_op(1'b1, 65521, 0);
        run_op(1'b1, 65535, 2);
        run_op(1'b1, 1009, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
